// File: rtl/usb_fs_in_pe_buffer.sv
// Single-packet IN endpoint buffer between an endpoint client and the USB FS protocol engine.
// Answers IN tokens with STALL/NAK/DATAx, keeps the data toggle and retransmits when the ACK is lost.
module usb_fs_in_pe_buffer #(
  parameter int MAX_PKT_SIZE = 32,
  parameter int PTR_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic       in_token,
  input  logic       setup_token,
  input  logic       rx_ack,
  output logic       tx_pid_valid,
  output logic [3:0] tx_pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data
);

  localparam int AW = $clog2(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] MAX_P = PTR_W'(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    FILL,
    READY,
    SEND,
    WAIT_ACK
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic             toggle_q, toggle_d;
  logic             grant_q, grant_d;
  logic             acked_q, acked_d;
  logic             pid_valid_q, pid_valid_d;
  logic [3:0]       pid_q, pid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             wr_en;
  logic             free;
  logic             avail;

  logic [7:0] mem_q [MAX_PKT_SIZE];

  assign free  = (state_q == FILL) && (wr_ptr_q < MAX_P);
  assign avail = (state_q == SEND) && (rd_ptr_q < len_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    toggle_d    = toggle_q;
    pid_d       = pid_q;
    pid_valid_d = 1'b0;
    acked_d     = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      FILL: begin
        if (in_ep_data_put && grant_q && free) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
        end
        // the byte written this cycle is counted before closing
        if (in_ep_data_done || (wr_en && wr_ptr_d == MAX_P)) begin
          len_d   = wr_ptr_d;
          state_d = READY;
        end
      end
      READY: begin
      end
      SEND: begin
        if (tx_data_get && avail) begin
          rd_ptr_d = rd_ptr_q + ONE;
        end
        if (rd_ptr_d == len_q) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (rx_ack && !in_token) begin
          toggle_d = ~toggle_q;
          acked_d  = 1'b1;
          wr_ptr_d = '0;
          len_d    = '0;
          state_d  = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    if (in_token) begin
      pid_valid_d = 1'b1;
      if (in_ep_stall) begin
        pid_d = PID_STALL;
      end else if (state_q == READY || state_q == WAIT_ACK) begin
        pid_d    = toggle_q ? PID_DATA1 : PID_DATA0;
        rd_ptr_d = '0;
        state_d  = SEND;
      end else begin
        pid_d = PID_NAK;
      end
    end

    if (setup_token) begin
      wr_en       = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      len_d       = '0;
      toggle_d    = 1'b1;
      pid_d       = pid_q;
      pid_valid_d = 1'b0;
      acked_d     = 1'b0;
      state_d     = FILL;
    end
  end

  assign grant_d   = in_ep_req && (state_d == FILL);
  assign tx_data_d = mem_q[rd_ptr_d[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      toggle_q    <= 1'b0;
      grant_q     <= 1'b0;
      acked_q     <= 1'b0;
      pid_valid_q <= 1'b0;
      pid_q       <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      toggle_q    <= toggle_d;
      grant_q     <= grant_d;
      acked_q     <= acked_d;
      pid_valid_q <= pid_valid_d;
      pid_q       <= pid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_ep_data;
    end
  end

  assign in_ep_grant     = grant_q;
  assign in_ep_data_free = free;
  assign in_ep_acked     = acked_q;
  assign tx_pid_valid    = pid_valid_q;
  assign tx_pid          = pid_q;
  assign tx_data_avail   = avail;
  assign tx_data         = tx_data_q;

endmodule

// File: tb/tb_usb_fs_in_pe_buffer.sv
// Directed bench for usb_fs_in_pe_buffer: fill, send, ack, NAK/STALL,
// retransmit, setup flush and asynchronous reset.
module tb_usb_fs_in_pe_buffer;

  localparam logic [3:0] D0 = 4'b0011;
  localparam logic [3:0] D1 = 4'b1011;
  localparam logic [3:0] NK = 4'b1010;
  localparam logic [3:0] ST = 4'b1110;

  logic       clk;
  logic       reset;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;
  logic       in_token;
  logic       setup_token;
  logic       rx_ack;
  logic       tx_pid_valid;
  logic [3:0] tx_pid;
  logic       tx_data_avail;
  logic       tx_data_get;
  logic [7:0] tx_data;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_b [64];

  usb_fs_in_pe_buffer #(
    .MAX_PKT_SIZE(32),
    .PTR_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ep_req(in_ep_req),
    .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked),
    .in_token(in_token),
    .setup_token(setup_token),
    .rx_ack(rx_ack),
    .tx_pid_valid(tx_pid_valid),
    .tx_pid(tx_pid),
    .tx_data_avail(tx_data_avail),
    .tx_data_get(tx_data_get),
    .tx_data(tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic fill(input int n, input bit close);
    chk("grant", in_ep_grant, 1);
    for (int i = 0; i < n; i++) begin
      in_ep_data_put = 1'b1;
      in_ep_data     = exp_b[i];
      tick();
    end
    in_ep_data_put = 1'b0;
    if (close) begin
      in_ep_data_done = 1'b1;
      tick();
      in_ep_data_done = 1'b0;
    end
    chk("free_ready", in_ep_data_free, 0);
    chk("grant_ready", in_ep_grant, 0);
  endtask

  task automatic token(input logic [3:0] pid);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    chk("pid_valid", tx_pid_valid, 1);
    chk("pid", tx_pid, pid);
  endtask

  task automatic read_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      chk("avail", tx_data_avail, 1);
      chk($sformatf("data%0d", i), tx_data, exp_b[i]);
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
    end
    chk("avail_end", tx_data_avail, 0);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    chk("acked", in_ep_acked, 1);
    tick();
    chk("acked_pulse", in_ep_acked, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    in_ep_req = 1'b0;
    in_ep_data_put = 1'b0;
    in_ep_data = '0;
    in_ep_data_done = 1'b0;
    in_ep_stall = 1'b0;
    in_token = 1'b0;
    setup_token = 1'b0;
    rx_ack = 1'b0;
    tx_data_get = 1'b0;
    tick();
    tick();
    chk("rst_grant", in_ep_grant, 0);
    chk("rst_free", in_ep_data_free, 1);
    chk("rst_acked", in_ep_acked, 0);
    chk("rst_pidv", tx_pid_valid, 0);
    chk("rst_pid", tx_pid, 0);
    chk("rst_avail", tx_data_avail, 0);
    chk("rst_data", tx_data, 0);
    reset = 1'b0;
    in_ep_req = 1'b1;
    tick();

    // 1: 18-byte packet, DATA0, ack
    exp_b[0] = 8'h12;
    for (int i = 1; i < 18; i++) exp_b[i] = 8'(i);
    fill(18, 1'b1);
    token(D0);
    read_pkt(18);
    chk("pidv_pulse", tx_pid_valid, 0);
    ack();
    chk("free_after_ack", in_ep_data_free, 1);

    // 2: 32 bytes auto-close, 33rd ignored
    do_reset();
    for (int i = 0; i < 32; i++) exp_b[i] = 8'(i * 5 + 3);
    fill(32, 1'b0);
    in_ep_data_put = 1'b1;
    in_ep_data = 8'hEE;
    tick();
    in_ep_data_put = 1'b0;
    chk("free_full", in_ep_data_free, 0);
    token(D0);
    read_pkt(32);
    ack();

    // 3: NAK in FILL, STALL keeps packet
    do_reset();
    token(NK);
    for (int i = 0; i < 4; i++) exp_b[i] = 8'hC0 + 8'(i);
    fill(4, 1'b1);
    in_ep_stall = 1'b1;
    token(ST);
    chk("stall_avail", tx_data_avail, 0);
    chk("stall_free", in_ep_data_free, 0);
    in_ep_stall = 1'b0;
    token(D0);
    read_pkt(4);
    ack();

    // 4: lost ACK, retransmit, then DATA1
    do_reset();
    for (int i = 0; i < 3; i++) exp_b[i] = 8'h55 + 8'(i * 17);
    fill(3, 1'b1);
    token(D0);
    read_pkt(3);
    tick();
    token(D0);
    read_pkt(3);
    ack();
    for (int i = 0; i < 2; i++) exp_b[i] = 8'h90 + 8'(i);
    fill(2, 1'b1);
    token(D1);
    chk("d1_data0", tx_data, exp_b[0]);

    // 5: setup during SEND flushes; zero-length DATA1
    tx_data_get = 1'b1;
    tick();
    tx_data_get = 1'b0;
    setup_token = 1'b1;
    tick();
    setup_token = 1'b0;
    chk("setup_free", in_ep_data_free, 1);
    chk("setup_avail", tx_data_avail, 0);
    chk("setup_grant", in_ep_grant, 1);
    fill(0, 1'b1);
    token(D1);
    chk("zlp_avail0", tx_data_avail, 0);
    tick();
    chk("zlp_avail1", tx_data_avail, 0);
    ack();

    // 6: async reset mid-SEND
    for (int i = 0; i < 4; i++) exp_b[i] = 8'h31 + 8'(i);
    fill(4, 1'b1);
    token(D0);
    tx_data_get = 1'b1;
    tick();
    tx_data_get = 1'b0;
    chk("pre_rst_avail", tx_data_avail, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_avail", tx_data_avail, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_free", in_ep_data_free, 1);
    chk("arst_grant", in_ep_grant, 0);
    chk("arst_pid", tx_pid, 0);
    chk("arst_pidv", tx_pid_valid, 0);
    chk("arst_acked", in_ep_acked, 0);
    tick();
    reset = 1'b0;
    tick();
    token(NK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
